mult32x32_fast_issue: RTL



---
 rtl/mult32x32_pkg.sv | 19 +
 rtl/mult_issue_fifo.sv | 57 +++++
 rtl/mult32x32_fast_issue.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mult32x32_pkg.sv
// Shared widths, issue-FSM state encoding and small helpers for the 32x32 multiplier issue front-end.
package mult32x32_pkg;

    localparam int OPERAND_W = 32;
    localparam int PRODUCT_W = 64;
    localparam int MSW_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } issue_state_e;

    function automatic logic msw_is_zero(input logic [OPERAND_W-1:0] value);
        return value[OPERAND_W-1 -: MSW_W] == '0;
    endfunction

endpackage

// File: rtl/mult_issue_fifo.sv
// Synchronous operand FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module mult_issue_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mult32x32_fast_issue.sv
// Issue front-end for the fast 32x32 multiplier: buffers operands, pulses start, returns products in order.
// Optional MULT_ISSUE_ZERO_SKIP_EN bypasses the multiplier for pairs with a zero operand.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | waiting for a FIFO entry; pops it into mult_a/mult_b
//  ST_START | one-cycle mult_start pulse
//  ST_WAIT  | waiting for busy to rise and then fall (product final)
//  ST_HOLD  | product ready (or zero-skip) but result register occupied
module mult32x32_fast_issue
    import mult32x32_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OPERAND_W-1:0]   in_a,
    input  logic [OPERAND_W-1:0]   in_b,
    output logic                   mult_start,
    output logic [OPERAND_W-1:0]   mult_a,
    output logic [OPERAND_W-1:0]   mult_b,
    output logic                   mult_a_msw_is_0,
    output logic                   mult_b_msw_is_0,
    input  logic                   mult_busy,
    input  logic [PRODUCT_W-1:0]   mult_product,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PRODUCT_W-1:0]   out_product
);

    issue_state_e                    state;
    logic                            seen_busy;
    logic                            skip_zero;
    logic                            fifo_full;
    logic                            fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]     fifo_count;
    logic [2*OPERAND_W-1:0]          head;
    logic [OPERAND_W-1:0]            head_a;
    logic [OPERAND_W-1:0]            head_b;
    logic                            head_valid;
    logic                            head_zero;
    logic                            pop;
    logic                            push;
    logic                            result_free;
    logic                            mult_done;
    logic                            capture;
    logic [PRODUCT_W-1:0]            capture_data;

    mult_issue_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2*OPERAND_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({in_a, in_b}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign in_ready    = !fifo_full;
    assign push        = in_valid && in_ready;
    assign head_a      = head[2*OPERAND_W-1:OPERAND_W];
    assign head_b      = head[OPERAND_W-1:0];
    assign head_valid  = !fifo_empty && (fifo_count != '0);
    assign pop         = (state == ST_IDLE) && head_valid;
    assign result_free = !out_valid || out_ready;
    assign mult_done   = seen_busy && !mult_busy;

`ifdef MULT_ISSUE_ZERO_SKIP_EN
    assign head_zero = (head_a == '0) || (head_b == '0);
`else
    assign head_zero = 1'b0;
`endif

    assign capture = ((state == ST_WAIT) && mult_done && result_free) ||
                     ((state == ST_HOLD) && result_free);
    assign capture_data = skip_zero ? '0 : mult_product;

    assign mult_start      = (state == ST_START);
    assign mult_a_msw_is_0 = msw_is_zero(mult_a);
    assign mult_b_msw_is_0 = msw_is_zero(mult_b);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            mult_a    <= '0;
            mult_b    <= '0;
            seen_busy <= 1'b0;
            skip_zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        mult_a    <= head_a;
                        mult_b    <= head_b;
                        skip_zero <= head_zero;
                        state     <= head_zero ? ST_HOLD : ST_START;
                    end
                end
                ST_START: begin
                    seen_busy <= 1'b0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mult_busy) begin
                        seen_busy <= 1'b1;
                    end
                    // Busy falling after it was seen high marks the product register final.
                    if (mult_done) begin
                        seen_busy <= 1'b0;
                        state     <= result_free ? ST_IDLE : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (result_free) begin
                        skip_zero <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            out_product <= '0;
        end else if (capture) begin
            out_valid   <= 1'b1;
            out_product <= capture_data;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule
